// File: rtl/npc_mem_pkg.sv
// Shared types and limits for the data memory port arbiter.
// The FSM state and requester-id enums are used by mem_port_arbiter and rr_arb2.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = IFU, bit 1 = LSU.
// On a tie the requester not granted last wins; history advances only on accept.
module rr_arb2
  import npc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e last_grant_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == REQ_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to LSU so the IFU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_LSU;
    end else if (accept && (grant != 2'b00)) begin
      last_grant_q <= grant[1] ? REQ_LSU : REQ_IFU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data memory port between IFU (read-only) and LSU (read/write),
// one outstanding transaction at a time with a fixed access latency.
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_resp_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_wr,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wstrb,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_resp_rdata,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  output state_e          dbg_state
);

  localparam int SW = DW / 8;

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
  // ready never waits on anything but state and valids, and valid never depends on ready.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  req_id_e           req_id_q;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [SW-1:0]     wstrb_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        grant;
  logic              idle;
  logic              req_hs;
  logic              access_done;
  logic              resp_take;

  assign idle        = (state_q == IDLE);
  assign req_hs      = idle && (grant != 2'b00);
  assign access_done = (state_q == ACCESS) && (cnt_q == '0);
  assign resp_take   = (req_id_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({lsu_req_valid, ifu_req_valid}),
    .accept (idle),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs)      state_d = ACCESS;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    if (resp_take)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      req_id_q <= REQ_IFU;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else if (req_hs) begin
      cnt_q <= CNT_W'(MEM_LAT - 1);
      if (grant[0]) begin
        req_id_q <= REQ_IFU;
        wr_q     <= 1'b0;
        addr_q   <= ifu_req_addr;
        wdata_q  <= '0;
        wstrb_q  <= '0;
      end else begin
        req_id_q <= REQ_LSU;
        wr_q     <= lsu_req_wr;
        addr_q   <= lsu_req_addr;
        wdata_q  <= lsu_req_wdata;
        wstrb_q  <= lsu_req_wstrb;
      end
    end else if (state_q == ACCESS) begin
      if (access_done) begin
        rdata_q <= wr_q ? '0 : mem_rdata;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // mem_en decodes straight from registers so an async reset kills it immediately.
  assign mem_en         = access_done;
  assign mem_wr         = wr_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;

  assign ifu_req_ready  = idle && grant[0];
  assign lsu_req_ready  = idle && grant[1];
  assign ifu_resp_valid = (state_q == RESP) && (req_id_q == REQ_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (req_id_q == REQ_LSU);
  assign ifu_resp_rdata = rdata_q;
  assign lsu_resp_rdata = rdata_q;
  assign dbg_state      = state_q;

endmodule
